simd_lane_assembler: RTL and testbench
======================================

// Module: simd_lane_assembler
// PURPOSE
//  Parametrised, clocked successor to the lane-insert unit: builds a WORD_W-bit SIMD word lane by lane.
//  Supported ops are INSERT, BROADCAST, LOAD and CLEAR, fed through a valid/ready input port.
//  Emits the completed word on a valid/ready output once every lane has been written.
//  Sits between the AES byte-level datapath and the SIMD vector register file (assembles state columns).
// PARAMETERS
//  LANE_W   8             bits per lane
//  LANES    4             lanes per word; power of 2, >=2
//  FILL     {WORD_W{1'b0}} value the accumulator takes on reset, CLEAR and after each emitted word
//  CNT_W    16            width of the emitted-word counter
//  (derived) WORD_W = LANE_W*LANES;  IDX_W = $clog2(LANES)
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  in_valid   in   1       input op valid
//  in_ready   out  1       block can accept an op
//  in_op      in   2       00 INSERT, 01 BROADCAST, 10 LOAD, 11 CLEAR
//  in_idx     in   IDX_W   target lane for INSERT (lane k = bits [k*LANE_W +: LANE_W])
//  in_data    in   WORD_W  INSERT/BROADCAST use [LANE_W-1:0]; LOAD uses all bits
//  out_valid  out  1       assembled word available
//  out_ready  in   1       consumer accepts word
//  out_data   out  WORD_W  assembled word (registered)
//  lane_mask  out  LANES   lanes written since last clear/emit
//  dup_err    out  1       sticky: INSERT hit an already-written lane
//  word_cnt   out  CNT_W   number of words emitted, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (async, rst_n=0): acc=FILL, lane_mask=0, state=EMPTY, out_valid=0, out_data=FILL, dup_err=0, word_cnt=0.
//  Accept = in_valid & in_ready. in_ready = (state != FULL).
//  FSM states: EMPTY (mask==0), PARTIAL (0<mask<all-ones), FULL (word awaiting hand-off).
//  Effect of an accepted op at posedge:
//   INSERT: acc lane[in_idx] <= in_data[LANE_W-1:0]; mask[in_idx] <= 1; if mask[in_idx] was already 1, dup_err <= 1 (write still applied).
//   BROADCAST: every lane <= in_data[LANE_W-1:0]; mask <= all ones.
//   LOAD: acc <= in_data; mask <= all ones.
//   CLEAR: acc <= FILL; mask <= 0; dup_err <= 0; state <= EMPTY.
//  If the post-op mask is all ones: state <= FULL; out_data <= new acc; out_valid <= 1 on the same edge.
//   Latency: the word is visible one cycle after the completing op is accepted.
//  Otherwise: state <= (mask==0 ? EMPTY : PARTIAL).
//  FULL: no ops accepted; out_data and out_valid hold stable until out_ready=1.
//  Hand-off (out_valid & out_ready) at posedge:
//   out_valid <= 0; acc <= FILL; mask <= 0; state <= EMPTY; word_cnt <= word_cnt+1 (wraps).
//   dup_err is unaffected by hand-off.
//  No input/output overlap: an op presented in the hand-off cycle is not accepted (in_ready=0) and is taken next cycle.
//  INSERT with in_idx >= LANES cannot occur (LANES is a power of 2).
//  Upper in_data bits are ignored for INSERT and BROADCAST.
//  out_valid never drops without a hand-off. out_data changes only on entering FULL or on reset.
//  rst_n asserted mid-assembly or while FULL: all state is discarded at once and the pending word is lost.
//  Assertions: !(out_valid && in_ready); $stable(out_data) while out_valid && !out_ready.
// TESTING (LANE_W=8, LANES=4, FILL=0)
//  1. INSERT idx0..3 with data 78,56,34,12 on back-to-back cycles, out_ready=1
//     -> out_valid 1 cycle after 4th accept; out_data=32'h12345678; word_cnt=1.
//  2. INSERT idx2 data AA, then idx2 data BB -> dup_err=1, lane_mask=4'b0100.
//     Then INSERT idx0,1,3 data 00 -> out_data=32'h00BB0000.
//  3. BROADCAST data 32'hxxxxxx3C -> out_data=32'h3C3C3C3C next cycle.
//     Hold out_ready=0 for 5 cycles -> in_ready=0 and out_data stable throughout.
//  4. LOAD 32'h87654321, out_ready=1 -> one word emitted. Repeat 2^16 words -> word_cnt wraps to 0.
//  5. INSERT idx1 data 55, then CLEAR -> lane_mask=0, dup_err=0, state EMPTY, no out_valid.
//  6. INSERT idx0..2, drop rst_n mid-cycle -> outputs take reset values immediately (asynchronous).
//     After release, a full 4-lane INSERT sequence yields a correct word.

Source files
------------

// File: rtl/simd_lane_assembler.sv
// Lane-by-lane SIMD word assembler: INSERT/BROADCAST/LOAD/CLEAR ops build a WORD_W-bit word.
// Latency: the completed word is valid one cycle after the op that fills the last lane is accepted.
// Backpressure: in_ready drops while a finished word waits; ops resume the cycle after hand-off.
module simd_lane_assembler #(
    parameter int                      LANE_W = 8,
    parameter int                      LANES  = 4,
    parameter logic [LANE_W*LANES-1:0] FILL   = '0,
    parameter int                      CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_op,
    input  logic [$clog2(LANES)-1:0]   in_idx,
    input  logic [LANE_W*LANES-1:0]    in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANE_W*LANES-1:0]    out_data,
    output logic [LANES-1:0]           lane_mask,
    output logic                       dup_err,
    output logic [CNT_W-1:0]           word_cnt
);

    localparam int WORD_W = LANE_W * LANES;

    localparam logic [1:0] OP_INSERT = 2'b00;
    localparam logic [1:0] OP_BCAST  = 2'b01;
    localparam logic [1:0] OP_LOAD   = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        PARTIAL = 2'b01,
        FULL    = 2'b10
    } state_t;

    state_t              state, state_nxt;
    logic [WORD_W-1:0]   acc, acc_nxt;
    logic [LANES-1:0]    mask_nxt;
    logic                dup_nxt;
    logic                load_out;
    logic                cnt_inc;

    // A finished word occupies the block until it is handed off, so FULL is both
    // the output-valid condition and the input stall condition.
    assign in_ready  = (state != FULL);
    assign out_valid = (state == FULL);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, next accumulator/mask and hand-off decode.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        mask_nxt  = lane_mask;
        dup_nxt   = dup_err;
        load_out  = 1'b0;
        cnt_inc   = 1'b0;
        if (state == FULL) begin
            if (out_ready) begin
                acc_nxt   = FILL;
                mask_nxt  = '0;
                state_nxt = EMPTY;
                cnt_inc   = 1'b1;
            end
        end else if (in_valid) begin
            case (in_op)
                OP_INSERT: begin
                    for (int k = 0; k < LANES; k++) begin
                        if (in_idx == ($clog2(LANES))'(k)) begin
                            acc_nxt[k*LANE_W +: LANE_W] = in_data[LANE_W-1:0];
                        end
                    end
                    // Rewriting a lane still takes effect; the flag only records it.
                    if (lane_mask[in_idx]) begin
                        dup_nxt = 1'b1;
                    end
                    mask_nxt[in_idx] = 1'b1;
                end
                OP_BCAST: begin
                    acc_nxt  = {LANES{in_data[LANE_W-1:0]}};
                    mask_nxt = '1;
                end
                OP_LOAD: begin
                    acc_nxt  = in_data;
                    mask_nxt = '1;
                end
                default: begin
                    acc_nxt  = FILL;
                    mask_nxt = '0;
                    dup_nxt  = 1'b0;
                end
            endcase
            if (&mask_nxt) begin
                state_nxt = FULL;
                load_out  = 1'b1;
            end else if (mask_nxt == '0) begin
                state_nxt = EMPTY;
            end else begin
                state_nxt = PARTIAL;
            end
        end
    end

    // Datapath registers: accumulator, mask, sticky error, output word and counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= FILL;
            lane_mask <= '0;
            dup_err   <= 1'b0;
            out_data  <= FILL;
            word_cnt  <= '0;
        end else begin
            acc       <= acc_nxt;
            lane_mask <= mask_nxt;
            dup_err   <= dup_nxt;
            if (load_out) begin
                out_data <= acc_nxt;
            end
            if (cnt_inc) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
        end
    end

    // A waiting word blocks new ops and must not change until it is taken.
    a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n)
        !(out_valid && in_ready));
    a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> $stable(out_data));

endmodule

// File: tb/tb_simd_lane_assembler.sv
module tb_simd_lane_assembler;

    localparam int LANE_W = 8;
    localparam int LANES  = 4;
    localparam int CNT_W  = 8;
    localparam int WORD_W = LANE_W * LANES;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        in_op = 2'b00;
    logic [1:0]        in_idx = 2'b00;
    logic [WORD_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [WORD_W-1:0] out_data;
    logic [LANES-1:0]  lane_mask;
    logic              dup_err;
    logic [CNT_W-1:0]  word_cnt;

    int errors = 0;
    int checks = 0;

    simd_lane_assembler #(
        .LANE_W(LANE_W), .LANES(LANES), .FILL('0), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_idx(in_idx), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .lane_mask(lane_mask), .dup_err(dup_err), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: an array of lane bytes with per-lane written flags.
    logic [LANE_W-1:0] m_lane [LANES];
    bit                m_wr   [LANES];
    bit                m_full;
    bit                m_dup;
    logic [WORD_W-1:0] m_out;
    int                m_cnt;

    function automatic logic [WORD_W-1:0] m_word();
        logic [WORD_W-1:0] w;
        for (int k = 0; k < LANES; k++) w[k*LANE_W +: LANE_W] = m_lane[k];
        return w;
    endfunction

    function automatic logic [LANES-1:0] m_mask();
        logic [LANES-1:0] mk;
        for (int k = 0; k < LANES; k++) mk[k] = m_wr[k];
        return mk;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < LANES; k++) begin
            m_lane[k] = '0;
            m_wr[k]   = 1'b0;
        end
        m_full = 1'b0;
        m_dup  = 1'b0;
        m_out  = '0;
        m_cnt  = 0;
    endtask

    // Drive one cycle of stimulus, advance the model across the edge, return at posedge+1.
    task automatic cycle(input logic v, input logic [1:0] op, input logic [1:0] idx,
                         input logic [WORD_W-1:0] d, input logic ordy);
        bit all;
        in_valid  = v;
        in_op     = op;
        in_idx    = idx;
        in_data   = d;
        out_ready = ordy;
        @(posedge clk);
        if (m_full) begin
            if (ordy) begin
                for (int k = 0; k < LANES; k++) begin
                    m_lane[k] = '0;
                    m_wr[k]   = 1'b0;
                end
                m_full = 1'b0;
                m_cnt  = (m_cnt + 1) % (1 << CNT_W);
            end
        end else if (v) begin
            case (op)
                2'b00: begin
                    if (m_wr[idx]) m_dup = 1'b1;
                    m_wr[idx]   = 1'b1;
                    m_lane[idx] = d[LANE_W-1:0];
                end
                2'b01: for (int k = 0; k < LANES; k++) begin
                    m_lane[k] = d[LANE_W-1:0];
                    m_wr[k]   = 1'b1;
                end
                2'b10: for (int k = 0; k < LANES; k++) begin
                    m_lane[k] = d[k*LANE_W +: LANE_W];
                    m_wr[k]   = 1'b1;
                end
                default: begin
                    for (int k = 0; k < LANES; k++) begin
                        m_lane[k] = '0;
                        m_wr[k]   = 1'b0;
                    end
                    m_dup = 1'b0;
                end
            endcase
            all = 1'b1;
            for (int k = 0; k < LANES; k++) if (!m_wr[k]) all = 1'b0;
            if (all) begin
                m_full = 1'b1;
                m_out  = m_word();
            end
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (lane_mask !== 4'b0) begin errors++; $display("FAIL reset_lane_mask got=%b exp=0", lane_mask); end
        checks++; if (dup_err !== 1'b0) begin errors++; $display("FAIL reset_dup_err got=%b exp=0", dup_err); end
        checks++; if (word_cnt !== 8'd0) begin errors++; $display("FAIL reset_word_cnt got=%0d exp=0", word_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_insert_seq();
        logic [7:0] bytes [4];
        bytes[0] = 8'h78; bytes[1] = 8'h56; bytes[2] = 8'h34; bytes[3] = 8'h12;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 2'b00, 2'(k), {24'hFFFFFF, bytes[k]}, 1'b1);
            if (k == 2) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ins_early_valid got=%b exp=0", out_valid); end
                checks++; if (lane_mask !== 4'b0111) begin errors++; $display("FAIL ins_mask3 got=%b exp=0111", lane_mask); end
            end
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ins_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 32'h12345678) begin errors++; $display("FAIL ins_data got=%h exp=12345678", out_data); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ins_in_ready got=%b exp=0", in_ready); end
        cycle(1'b0, 2'b00, 2'b00, '0, 1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ins_handoff_valid got=%b exp=0", out_valid); end
        checks++; if (word_cnt !== 8'd1) begin errors++; $display("FAIL ins_word_cnt got=%0d exp=1", word_cnt); end
    endtask

    task automatic test_dup();
        cycle(1'b1, 2'b00, 2'd2, 32'h0000_00AA, 1'b1);
        cycle(1'b1, 2'b00, 2'd2, 32'h0000_00BB, 1'b1);
        checks++; if (dup_err !== 1'b1) begin errors++; $display("FAIL dup_flag got=%b exp=1", dup_err); end
        checks++; if (lane_mask !== 4'b0100) begin errors++; $display("FAIL dup_mask got=%b exp=0100", lane_mask); end
        cycle(1'b1, 2'b00, 2'd0, 32'h0, 1'b1);
        cycle(1'b1, 2'b00, 2'd1, 32'h0, 1'b1);
        cycle(1'b1, 2'b00, 2'd3, 32'h0, 1'b1);
        checks++; if (out_data !== 32'h00BB0000) begin errors++; $display("FAIL dup_word got=%h exp=00bb0000", out_data); end
        cycle(1'b0, 2'b00, 2'd0, 32'h0, 1'b1);
        checks++; if (dup_err !== 1'b1) begin errors++; $display("FAIL dup_sticky got=%b exp=1", dup_err); end
        checks++; if (word_cnt !== 8'd2) begin errors++; $display("FAIL dup_word_cnt got=%0d exp=2", word_cnt); end
    endtask

    task automatic test_backpressure();
        cycle(1'b1, 2'b01, 2'd0, 32'hABCDEF3C, 1'b0);
        checks++; if (out_data !== 32'h3C3C3C3C) begin errors++; $display("FAIL bc_data got=%h exp=3c3c3c3c", out_data); end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 2'b00, 2'd0, 32'h11, 1'b0);
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold rdy=%b vld=%b exp rdy=0 vld=1", in_ready, out_valid); end
            checks++; if (out_data !== 32'h3C3C3C3C) begin errors++; $display("FAIL bp_stable got=%h exp=3c3c3c3c", out_data); end
        end
        // Op offered during hand-off is refused, then taken on the next cycle.
        in_valid = 1'b1;
        cycle(1'b1, 2'b00, 2'd0, 32'h11, 1'b1);
        checks++; if (lane_mask !== 4'b0000) begin errors++; $display("FAIL bp_no_overlap got=%b exp=0000", lane_mask); end
        cycle(1'b1, 2'b00, 2'd0, 32'h11, 1'b1);
        checks++; if (lane_mask !== 4'b0001) begin errors++; $display("FAIL bp_taken_next got=%b exp=0001", lane_mask); end
        cycle(1'b1, 2'b11, 2'd0, 32'h0, 1'b1);
    endtask

    task automatic test_wrap();
        cycle(1'b1, 2'b10, 2'd0, 32'h87654321, 1'b1);
        checks++; if (out_data !== 32'h87654321) begin errors++; $display("FAIL load_data got=%h exp=87654321", out_data); end
        cycle(1'b0, 2'b00, 2'd0, 32'h0, 1'b1);
        checks++; if (word_cnt !== CNT_W'(m_cnt)) begin errors++; $display("FAIL load_cnt got=%0d exp=%0d", word_cnt, m_cnt); end
        while (m_cnt != 0) begin
            cycle(1'b1, 2'b10, 2'd0, $urandom, 1'b1);
            cycle(1'b0, 2'b00, 2'd0, 32'h0, 1'b1);
        end
        checks++; if (word_cnt !== 8'd0) begin errors++; $display("FAIL wrap_cnt got=%0d exp=0", word_cnt); end
        checks++; if (out_data !== m_out) begin errors++; $display("FAIL wrap_data got=%h exp=%h", out_data, m_out); end
    endtask

    task automatic test_clear();
        cycle(1'b1, 2'b00, 2'd1, 32'h55, 1'b1);
        cycle(1'b1, 2'b00, 2'd1, 32'h55, 1'b1);
        checks++; if (lane_mask !== 4'b0010 || dup_err !== 1'b1) begin errors++; $display("FAIL clr_pre mask=%b dup=%b exp 0010/1", lane_mask, dup_err); end
        cycle(1'b1, 2'b11, 2'd0, 32'h0, 1'b1);
        checks++; if (lane_mask !== 4'b0000) begin errors++; $display("FAIL clr_mask got=%b exp=0000", lane_mask); end
        checks++; if (dup_err !== 1'b0) begin errors++; $display("FAIL clr_dup got=%b exp=0", dup_err); end
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL clr_state vld=%b rdy=%b exp 0/1", out_valid, in_ready); end
    endtask

    task automatic test_async_reset();
        logic [WORD_W-1:0] d;
        for (int k = 0; k < 3; k++) cycle(1'b1, 2'b00, 2'(k), $urandom, 1'b1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (lane_mask !== 4'b0 || out_data !== 32'h0) begin errors++; $display("FAIL arst_now mask=%b data=%h exp 0/0", lane_mask, out_data); end
        checks++; if (word_cnt !== 8'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL arst_cnt cnt=%0d rdy=%b exp 0/1", word_cnt, in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        d = $urandom;
        for (int k = 0; k < 4; k++) cycle(1'b1, 2'b00, 2'(k), {24'h0, d[k*8 +: 8]}, 1'b1);
        checks++; if (out_valid !== 1'b1 || out_data !== d) begin errors++; $display("FAIL arst_word vld=%b got=%h exp=%h", out_valid, out_data, d); end
    endtask

    task automatic test_random();
        logic [1:0] op;
        int r;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            op = (r < 6) ? 2'b00 : (r == 6) ? 2'b01 : (r == 7) ? 2'b10 : 2'b11;
            cycle(($urandom_range(0, 4) != 0), op, 2'($urandom_range(0, 3)), $urandom,
                  ($urandom_range(0, 3) != 0));
            checks++; if (out_valid !== m_full) begin errors++; $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, out_valid, m_full); end
            checks++; if (in_ready !== !m_full) begin errors++; $display("FAIL rnd_ready i=%0d got=%b exp=%b", i, in_ready, !m_full); end
            checks++; if (out_data !== m_out) begin errors++; $display("FAIL rnd_data i=%0d got=%h exp=%h", i, out_data, m_out); end
            checks++; if (lane_mask !== m_mask()) begin errors++; $display("FAIL rnd_mask i=%0d got=%b exp=%b", i, lane_mask, m_mask()); end
            checks++; if (dup_err !== m_dup) begin errors++; $display("FAIL rnd_dup i=%0d got=%b exp=%b", i, dup_err, m_dup); end
            checks++; if (word_cnt !== CNT_W'(m_cnt)) begin errors++; $display("FAIL rnd_cnt i=%0d got=%0d exp=%0d", i, word_cnt, m_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_insert_seq();
        test_dup();
        test_backpressure();
        test_wrap();
        test_clear();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
